// File: rtl/load_store_unit.sv
// RV32I load/store initiator on a word-wide memory without byte enables; sub-word stores are read-modify-write.
// Latency: 1 cycle (error), 2 (SW), 3 (load), 4 (SB/SH). req_ready is high only when idle, with one request in flight.
module load_store_unit #(
  parameter int MEM_AW = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ISSUE, S_RD_DATA, S_WRITE, S_RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [MEM_AW-1:0]  idx_q;
  logic [31:0]        wr_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic        accept;
  logic        illegal, misaligned, out_of_range, req_err;
  logic [31:0] lane, load_ext, lane_mask, merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    illegal      = req_we ? (req_funct3 > 3'd2)
                          : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
    misaligned   = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    out_of_range = |req_addr[31:MEM_AW+2];
    req_err      = illegal || misaligned || out_of_range;
  end

  // Halfwords are aligned here, so the byte-lane shift also selects the half lane.
  always_comb begin
    lane = mem_rd >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    load_ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_ext = {24'd0, lane[7:0]};
      3'd5:    load_ext = {16'd0, lane[15:0]};
      default: load_ext = mem_rd;
    endcase
    lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
    merged    = (mem_rd & ~lane_mask) | ((wr_q << {off_q, 3'b000}) & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                          state_d = S_RESP;
          else if (req_we && req_funct3 == 3'd2) state_d = S_WRITE;
          else                                  state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_DATA;
      S_RD_DATA:  state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE:    state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    mem_we    = (state_q == S_WRITE);
    mem_addr  = (state_q == S_IDLE) ? 32'd0 : 32'(idx_q);
    mem_wd    = (state_q == S_WRITE) ? wr_q : 32'd0;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // Response registers only change on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wr_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q  <= req_we;
        f3_q  <= req_funct3;
        off_q <= req_addr[1:0];
        idx_q <= req_addr[MEM_AW+1:2];
        wr_q  <= req_wdata;
        if (req_err) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end
      end
      if (state_q == S_RD_DATA) begin
        if (we_q) begin
          wr_q <= merged;
        end else begin
          rdata_q <= load_ext;
          err_q   <= 1'b0;
        end
      end
      if (state_q == S_WRITE) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory with registered read, reference word array and expectation queue.
module tb_load_store_unit;
  localparam int MEM_AW = 17;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  load_store_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem     [0:(1<<MEM_AW)-1];
  logic [31:0] ref_mem [0:(1<<MEM_AW)-1];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[MEM_AW-1:0]] <= mem_wd;
    mem_rd <= mem[mem_addr[MEM_AW-1:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        has_wr;
    logic [31:0] idx;
    logic [31:0] wdata;
    int          acc;
  } exp_t;
  exp_t q[$];

  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit   illegal, mis, oor;
    logic [31:0] nbytes;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    nbytes  = 32'd1 << f3[1:0];
    mis     = (a & (nbytes - 32'd1)) != 32'd0;
    oor     = a >= (32'd4 << MEM_AW);
    return illegal || mis || oor;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * a[1:0]);
    case (f3)
      3'd0:    return 32'($signed(v[7:0]));
      3'd1:    return 32'($signed(v[15:0]));
      3'd4:    return 32'(v[7:0]);
      3'd5:    return 32'(v[15:0]);
      default: return w;
    endcase
  endfunction

  // Every cycle: outputs must match what the oldest outstanding request implies at its age.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
    end else if (q.size() > 0 && cyc >= q[0].acc) begin
      e   = q[0];
      rel = cyc - e.acc + 1;
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      chk("busy_mem_addr", mem_addr, e.idx);
      chk("mem_we_timing", 32'(mem_we), 32'(e.has_wr && rel == e.lat - 1));
      if (mem_we) begin
        chk("mem_wd", mem_wd, e.wdata);
        last_waddr = mem_addr;
        last_wdata = mem_wd;
      end
      chk("rsp_valid_timing", 32'(rsp_valid), 32'(rel == e.lat));
      if (rel >= e.lat) begin
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.has_wr) ref_mem[e.idx[MEM_AW-1:0]] = e.wdata;
        void'(q.pop_front());
      end
    end else begin
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      if (req_ready) chk("idle_mem_addr", mem_addr, 32'd0);
    end
  end

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit keep);
    exp_t        e;
    int          n;
    logic [31:0] old, mask;
    int          sh;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 40);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready: req_ready stayed 0 for %0d cycles, required 1", n);
    end
    e.err    = model_err(we, f3, a);
    e.idx    = (a >> 2) & ((32'd1 << MEM_AW) - 32'd1);
    old      = ref_mem[e.idx[MEM_AW-1:0]];
    sh       = 8 * a[1:0];
    e.has_wr = we && !e.err;
    e.acc    = cyc + 1;
    e.lat    = e.err ? 1 : (we ? ((f3 == 3'd2) ? 2 : 4) : 3);
    e.rdata  = (e.err || we) ? 32'd0 : model_load(f3, a, old);
    mask     = (f3 == 3'd2) ? 32'hFFFF_FFFF : (((f3 == 3'd1) ? 32'h0000_FFFF : 32'h0000_00FF) << sh);
    e.wdata  = (old & ~mask) | ((wd << sh) & mask);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    q.push_back(e);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: %0d responses still pending, required 0", q.size());
      q.delete();
    end
  endtask

  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] exp; } ld_vec_t;
  ld_vec_t ld_vecs[5] = '{
    '{3'd0, 32'h13, 32'hFFFF_FF80},
    '{3'd4, 32'h13, 32'h0000_0080},
    '{3'd1, 32'h12, 32'hFFFF_80FF},
    '{3'd5, 32'h10, 32'h0000_7F01},
    '{3'd0, 32'h10, 32'h0000_0001}
  };

  typedef struct { logic we; logic [2:0] f3; logic [31:0] a; } er_vec_t;
  er_vec_t er_vecs[4] = '{
    '{1'b0, 3'd2, 32'h12},
    '{1'b1, 3'd1, 32'h11},
    '{1'b0, 3'd3, 32'h10},
    '{1'b0, 3'd2, 32'd1 << (MEM_AW + 2)}
  };

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    send(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0);
    wait_done();
    chk("sw_mem_addr", last_waddr, 32'd4);
    chk("sw_mem_wd", last_wdata, 32'hDEAD_BEEF);
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    wait_done();
    chk("lw_readback", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_readback_err", 32'(rsp_err), 32'd0);

    send(1'b1, 3'd2, 32'h10, 32'h80FF_7F01, 1'b0);
    wait_done();
    foreach (ld_vecs[i]) begin
      send(1'b0, ld_vecs[i].f3, ld_vecs[i].a, 32'd0, 1'b0);
      wait_done();
      chk($sformatf("load_vec%0d", i), rsp_rdata, ld_vecs[i].exp);
    end

    send(1'b1, 3'd2, 32'h10, 32'h1122_3344, 1'b0);
    wait_done();
    send(1'b1, 3'd0, 32'h11, 32'h0000_00AB, 1'b0);
    wait_done();
    chk("sb_written_word", last_wdata, 32'h1122_AB44);
    send(1'b1, 3'd1, 32'h12, 32'h0000_CDEF, 1'b0);
    wait_done();
    chk("sh_written_word", last_wdata, 32'hCDEF_AB44);
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    wait_done();
    chk("rmw_readback", rsp_rdata, 32'hCDEF_AB44);

    foreach (er_vecs[i]) begin
      send(er_vecs[i].we, er_vecs[i].f3, er_vecs[i].a, 32'hFFFF_FFFF, 1'b0);
      wait_done();
      chk($sformatf("err_vec%0d_err", i), 32'(rsp_err), 32'd1);
      chk($sformatf("err_vec%0d_rdata", i), rsp_rdata, 32'd0);
    end

    send(1'b1, 3'd2, 32'h14, 32'h5555_AAAA, 1'b0);
    wait_done();
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    send(1'b0, 3'd2, 32'h14, 32'd0, 1'b1);
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);
    wait_done();
    req_valid = 1'b0;
    chk("b2b_last_rdata", rsp_rdata, 32'hCDEF_AB44);
    repeat (3) @(negedge clk);

    // SB aborted by reset in its RD_DATA cycle.
    send(1'b1, 3'd0, 32'h11, 32'h0000_0077, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready), 32'd1);
    send(1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    wait_done();
    chk("word_unmodified", rsp_rdata, 32'hCDEF_AB44);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. Accepts one load or store request at a time from the execute stage and converts RV32I byte, halfword and word accesses into word-wide accesses on the data memory. The data memory is word-indexed, has a registered read with 1-cycle latency, and has no byte enables. Sub-word stores are therefore done as read-modify-write, and load data is extracted and sign- or zero-extended here.

## Interface
- MEM_AW, default 17: word-index width of the data memory (2^MEM_AW words).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid: misaligned, out of range, or illegal funct3
- mem_addr  out  32  word index, equal to req_addr[MEM_AW+1:2] zero-extended
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data; valid the cycle after the cycle mem_addr was presented with mem_we=0

## Operation
- Acceptance latches the request. Every output after that point comes from the latched copy; request inputs are don't-care until req_ready is high again.
- Error check at acceptance, in priority order:
  - illegal funct3: load with 3, 6 or 7; store with funct3 > 2
  - misaligned: halfword with addr[0]=1; word with addr[1:0]≠0
  - out of range: req_addr[31:MEM_AW+2]≠0
- Any error goes to RESP with rsp_err=1 and rsp_rdata=0. No memory write is ever issued for an errored request.
- States and transitions:
  - IDLE: req_ready=1.
    - Error → RESP.
    - SW → WRITE.
    - Load, SB or SH → RD_ISSUE.
  - RD_ISSUE: mem_addr driven, mem_we=0. → RD_DATA.
  - RD_DATA: mem_rd is valid.
    - Load: capture the extended byte/half/word into the rsp_rdata register → RESP.
    - SB/SH: merge the store lane into mem_rd, register it as the write word → WRITE.
  - WRITE: mem_we=1; mem_wd = req_wdata (SW) or the merged word. → RESP.
  - RESP: rsp_valid=1, req_ready=0. → IDLE.
- Lane selection is little-endian:
  - byte lane = addr[1:0]
  - half lane = addr[1] (bits 15:0 or 31:16)
- Merge replaces only the addressed byte or half. All other bits keep their mem_rd value.
- Load extension:
  - LB/LH replicate the sign bit of the selected lane.
  - LBU/LHU zero-fill.
  - LW passes the word through.
- mem_we is high only in WRITE. mem_addr holds the latched word index in every non-IDLE state and is 0 in IDLE.

## Timing
Edge 0 is the accepting edge. Latency is counted in cycles from edge 0 to the rsp_valid cycle:

| Access | States after acceptance | rsp_valid cycle | req_ready high again |
|---|---|---|---|
| Error | RESP | 1 | 2 |
| SW | WRITE, RESP | 2 | 3 |
| Load | RD_ISSUE, RD_DATA, RESP | 3 | 4 |
| SB/SH | RD_ISSUE, RD_DATA, WRITE, RESP | 4 | 5 |

- At most one request is outstanding. The minimum gap between accepts is (latency + 1) cycles.
- rsp_rdata and rsp_err hold their values after rsp_valid falls, until the next response overwrites them.
- Reset (asynchronous, any state):
  - state = IDLE
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - mem_we = 0, mem_addr = 0, mem_wd = 0
  - req_ready = 1 once rst_n deasserts
- Reset during WRITE: mem_we drops immediately. If it drops before the edge, the memory is not written.
- A request aborted by reset produces no rsp_valid.

## Test plan
- Write then read back:
  - SW addr 0x10, wdata 0xDEADBEEF → mem_we=1 with mem_addr=4, mem_wd=0xDEADBEEF in cycle 1; rsp_valid in cycle 2.
  - Then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle 3.
- Loads from word 4 = 0x80FF7F01:
  - LB 0x13 → 0xFFFFFF80
  - LBU 0x13 → 0x00000080
  - LH 0x12 → 0xFFFF80FF
  - LHU 0x10 → 0x00007F01
  - LB 0x10 → 0x00000001
- Sub-word stores to word 4 = 0x11223344:
  - SB 0x11, wdata 0xAB → written word 0x1122AB44, mem_we exactly one cycle, rsp_valid in cycle 4.
  - Then SH 0x12, wdata 0xCDEF → 0xCDEFAB44.
- Errors:
  - LW 0x12 → rsp_err=1, rsp_rdata=0.
  - SH 0x11 → rsp_err=1.
  - Load funct3=3 → rsp_err=1.
  - Address 1<<(MEM_AW+2) → rsp_err=1.
  - All four: rsp_valid in cycle 1 and mem_we never asserted.
- Handshake:
  - Hold req_valid high with back-to-back LWs → req_ready low from accept until the cycle after RESP; each request is accepted exactly once; responses arrive in order.
- Reset: assert rst_n=0 during the RD_DATA cycle of an SB → no memory write, no rsp_valid, all outputs 0; req_ready=1 after release, and a following LW returns the unmodified word.
